// File: rtl/rv32ima_pkg.sv
// Package: rv32ima_pkg
// Shared types and constants for the rv32ima core and its system-level helpers.
//   word_t          32-bit architectural word
//   mon_state_t     riscv_test_monitor FSM states
//   TOHOST_DEFAULT  default byte address of the riscv-tests tohost word
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MON_RUN,
    MON_SETTLE,
    MON_DONE,
    MON_TIMEOUT
  } mon_state_t;

  localparam word_t TOHOST_DEFAULT = 32'h8000_1000;

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Module: sat_counter
// Up-counter that saturates at all-ones instead of wrapping.
// Ports:
//   clk    in   1  clock
//   nrst   in   1  asynchronous active-low reset (clears count)
//   en     in   1  count enable; count holds when low
//   count  out  W  current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Module: riscv_test_monitor
// End-of-test detector for riscv-tests images. Snoops the data-memory write
// bus for a tohost write and the CSR exception pulse (ECALL); after an ECALL
// it waits SETTLE_CYCLES and samples gp (x3) to decide pass/fail.
// Optional feature macro: TEST_MONITOR_TIMEOUT_EN (adds a run-cycle timeout).
// Ports:
//   clk            in   1      system clock
//   nrst           in   1      asynchronous active-low reset
//   exception_hit  in   1      single-cycle ECALL/trap pulse
//   gp_value       in   32     live value of x3
//   dmem_wen       in   1      data-memory write request
//   dmem_ready     in   1      data-memory accepts the access this cycle
//   dmem_addr      in   32     data-memory byte address
//   dmem_wdata     in   32     data-memory write data
//   done           out  1      test finished (sticky until reset)
//   pass           out  1      1 = pass, valid when done
//   timeout        out  1      done was caused by the timeout
//   fail_code      out  31     test number / failure code, 0 on pass
//   cycles         out  CNT_W  cycles spent in RUN+SETTLE, frozen once done
module riscv_test_monitor
  import rv32ima_pkg::*;
#(
  parameter word_t       TOHOST_ADDR    = TOHOST_DEFAULT,
  parameter int unsigned SETTLE_CYCLES  = 50,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             exception_hit,
  input  logic [31:0]      gp_value,
  input  logic             dmem_wen,
  input  logic             dmem_ready,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycles
);

  mon_state_t  state, state_d;
  logic [7:0]  settle_q, settle_d;
  logic        done_d, pass_d;
  logic [30:0] code_d;
  logic        active;
  logic        tohost_hit;

  assign active = (state == MON_RUN) || (state == MON_SETTLE);

  // Even tohost values are syscall-proxy requests and are not terminations.
  assign tohost_hit = dmem_wen && dmem_ready && (dmem_addr == TOHOST_ADDR) && dmem_wdata[0];

`ifdef TEST_MONITOR_TIMEOUT_EN
  localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;
  logic timeout_hit;
  logic timeout_d;
  // Widen both sides so a narrow counter never aliases the limit.
  assign timeout_hit = (CMP_W'(cycles) == CMP_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d  = state;
    settle_d = settle_q;
    done_d   = done;
    pass_d   = pass;
    code_d   = fail_code;
`ifdef TEST_MONITOR_TIMEOUT_EN
    timeout_d = timeout;
`endif
    case (state)
      MON_RUN, MON_SETTLE: begin
        if (tohost_hit) begin
          state_d = MON_DONE;
          done_d  = 1'b1;
          pass_d  = (dmem_wdata == 32'd1);
          code_d  = dmem_wdata[31:1];
        end else if ((state == MON_SETTLE) && (settle_q == 8'd1)) begin
          state_d = MON_DONE;
          done_d  = 1'b1;
          pass_d  = (gp_value == 32'd1);
          code_d  = gp_value[31:1];
`ifdef TEST_MONITOR_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d   = MON_TIMEOUT;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          code_d    = '1;
`endif
        end else if ((state == MON_RUN) && exception_hit) begin
          state_d  = MON_SETTLE;
          settle_d = 8'(SETTLE_CYCLES);
        end else if (state == MON_SETTLE) begin
          settle_d = settle_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= MON_RUN;
      settle_q  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= '0;
    end else begin
      state     <= state_d;
      settle_q  <= settle_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_code <= code_d;
    end
  end

`ifdef TEST_MONITOR_TIMEOUT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Counting on the current state makes the terminating edge part of the count.
  sat_counter #(
    .W (CNT_W)
  ) u_cycles (
    .clk   (clk),
    .nrst  (nrst),
    .en    (active),
    .count (cycles)
  );

endmodule

// File: tb/tb_riscv_test_monitor.sv
module tb_riscv_test_monitor;

  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam int unsigned SETTLE = 50;

  logic        tb_clk = 1'b0;
  logic        nrst = 1'b0;
  logic        exception_hit = 1'b0;
  logic [31:0] gp_value = '0;
  logic        dmem_wen = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        done, pass, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycles;

  logic        s_done, s_pass, s_timeout;
  logic [30:0] s_code;
  logic [3:0]  s_cycles;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned edges    = 0;

  always #5 tb_clk = ~tb_clk;

  riscv_test_monitor #(
    .TOHOST_ADDR    (TOHOST),
    .SETTLE_CYCLES  (SETTLE),
    .CNT_W          (32),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (tb_clk),
    .nrst          (nrst),
    .exception_hit (exception_hit),
    .gp_value      (gp_value),
    .dmem_wen      (dmem_wen),
    .dmem_ready    (dmem_ready),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .fail_code     (fail_code),
    .cycles        (cycles)
  );

  // Narrow-counter instance used only to observe saturation.
  riscv_test_monitor #(
    .TOHOST_ADDR    (TOHOST),
    .SETTLE_CYCLES  (SETTLE),
    .CNT_W          (4),
    .TIMEOUT_CYCLES (1000)
  ) dut_sat (
    .clk           (tb_clk),
    .nrst          (nrst),
    .exception_hit (exception_hit),
    .gp_value      (gp_value),
    .dmem_wen      (dmem_wen),
    .dmem_ready    (dmem_ready),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .done          (s_done),
    .pass          (s_pass),
    .timeout       (s_timeout),
    .fail_code     (s_code),
    .cycles        (s_cycles)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic d, input logic p, input logic t,
                         input logic [30:0] code, input logic [31:0] cyc);
    chk({tag, ".done"}, 64'(done), 64'(d));
    chk({tag, ".pass"}, 64'(pass), 64'(p));
    chk({tag, ".timeout"}, 64'(timeout), 64'(t));
    chk({tag, ".fail_code"}, 64'(fail_code), 64'(code));
    chk({tag, ".cycles"}, 64'(cycles), 64'(cyc));
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
    edges++;
  endtask

  task automatic idle();
    exception_hit = 1'b0;
    dmem_wen      = 1'b0;
    dmem_ready    = 1'b0;
    dmem_addr     = '0;
    dmem_wdata    = '0;
  endtask

  task automatic do_reset();
    idle();
    nrst = 1'b0;
    @(posedge tb_clk);
    #4 nrst = 1'b1;
    edges = 0;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic rdy);
    exception_hit = 1'b0;
    dmem_wen      = 1'b1;
    dmem_ready    = rdy;
    dmem_addr     = addr;
    dmem_wdata    = data;
  endtask

  // Bus activity that can never count as a tohost termination.
  task automatic drive_noise();
    int unsigned k;
    k = $urandom_range(0, 3);
    exception_hit = 1'b0;
    gp_value      = $urandom;
    dmem_wen      = 1'b1;
    dmem_ready    = 1'b1;
    dmem_addr     = TOHOST;
    dmem_wdata    = $urandom;
    case (k)
      0: dmem_wen = 1'b0;
      1: dmem_addr = TOHOST ^ (32'd1 << $urandom_range(0, 31));
      2: dmem_ready = 1'b0;
      default: dmem_wdata[0] = 1'b0;
    endcase
  endtask

  task automatic run_noise(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive_noise();
      tick();
      chk("noise.done", 64'(done), 64'd0);
      chk("noise.cycles", 64'(cycles), 64'(edges));
    end
    idle();
  endtask

  // Issue an ECALL and walk through the settle window; returns with the
  // monitor one tick before gp is sampled.
  task automatic enter_settle_window(input int unsigned len);
    exception_hit = 1'b1;
    tick();
    for (int unsigned i = 1; i < len; i++) begin
      drive_noise();
      exception_hit = ((i % 10) == 0);
      tick();
      chk("settle.done", 64'(done), 64'd0);
    end
    idle();
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] g;
    logic [31:0] gps [3];
    int unsigned d;
    int unsigned p;
    int unsigned hold;

    // Reset state and 20-cycle tohost pass, with saturation of a 4-bit counter.
    do_reset();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);
    chk("sat.reset", 64'(s_cycles), 64'd0);
    for (int unsigned i = 0; i < 20; i++) begin
      drive_noise();
      tick();
      chk("sat.cycles", 64'(s_cycles), 64'((edges > 15) ? 15 : edges));
    end
    write(TOHOST, 32'h1, 1'b1);
    tick();
    idle();
    chk_out("tohost_pass", 1'b1, 1'b1, 1'b0, 31'd0, 32'd21);
    for (int unsigned i = 0; i < 5; i++) begin
      write(TOHOST, 32'h7, 1'b1);
      exception_hit = 1'b1;
      tick();
    end
    idle();
    chk_out("pass_sticky", 1'b1, 1'b1, 1'b0, 31'd0, 32'd21);

    // Tohost fail code, then a later pass write must not change anything.
    do_reset();
    d = $urandom_range(0, 30);
    run_noise(d);
    write(TOHOST, 32'h7, 1'b1);
    tick();
    idle();
    chk_out("tohost_fail", 1'b1, 1'b0, 1'b0, 31'd3, 32'(d + 1));
    write(TOHOST, 32'h1, 1'b1);
    tick();
    tick();
    idle();
    chk_out("fail_sticky", 1'b1, 1'b0, 1'b0, 31'd3, 32'(d + 1));

    // Writes that must be ignored.
    do_reset();
    write(TOHOST + 32'd4, 32'h1, 1'b1);
    tick();
    chk_out("ign_addr", 1'b0, 1'b0, 1'b0, 31'd0, 32'd1);
    write(TOHOST, 32'h1, 1'b0);
    tick();
    chk_out("ign_ready", 1'b0, 1'b0, 1'b0, 31'd0, 32'd2);
    write(TOHOST, 32'h2, 1'b1);
    tick();
    chk_out("ign_even", 1'b0, 1'b0, 1'b0, 31'd0, 32'd3);
    idle();

    // Random odd tohost values after random quiet periods.
    for (int unsigned it = 0; it < 6; it++) begin
      do_reset();
      d = $urandom_range(0, 30);
      run_noise(d);
      w = $urandom | 32'h1;
      if (it == 0) w = 32'h1;
      write(TOHOST, w, 1'b1);
      tick();
      idle();
      chk_out("tohost_rand", 1'b1, (w == 32'h1), 1'b0, w[31:1], 32'(d + 1));
    end

    // ECALL path: gp sampled at the end of the settle window.
    gps[0] = 32'd1;
    gps[1] = 32'd9;
    gps[2] = $urandom;
    for (int unsigned it = 0; it < 3; it++) begin
      do_reset();
      d = $urandom_range(0, 20);
      run_noise(d);
      enter_settle_window(SETTLE);
      g = gps[it];
      gp_value = g;
      tick();
      gp_value = $urandom;
      chk_out("ecall", 1'b1, (g == 32'd1), 1'b0, g[31:1], 32'(d + SETTLE + 1));
      tick();
      chk_out("ecall_sticky", 1'b1, (g == 32'd1), 1'b0, g[31:1], 32'(d + SETTLE + 1));
    end

    // Tohost write during SETTLE terminates immediately.
    do_reset();
    d = $urandom_range(0, 20);
    run_noise(d);
    p = $urandom_range(2, SETTLE - 1);
    enter_settle_window(p);
    gp_value = 32'd1;
    write(TOHOST, 32'h5, 1'b1);
    tick();
    idle();
    chk_out("settle_tohost", 1'b1, 1'b0, 1'b0, 31'd2, 32'(d + p + 1));

    // Tohost beats settle expiry.
    do_reset();
    enter_settle_window(SETTLE);
    gp_value = 32'd1;
    write(TOHOST, 32'h3, 1'b1);
    tick();
    idle();
    chk_out("expiry_prio", 1'b1, 1'b0, 1'b0, 31'd1, 32'(SETTLE + 1));

    // Tohost beats exception_hit in the same cycle.
    do_reset();
    d = $urandom_range(0, 20);
    run_noise(d);
    gp_value = 32'd5;
    write(TOHOST, 32'h1, 1'b1);
    exception_hit = 1'b1;
    tick();
    idle();
    chk_out("exc_prio", 1'b1, 1'b1, 1'b0, 31'd0, 32'(d + 1));

    // Asynchronous reset mid-SETTLE, then the monitor must be back in RUN.
    do_reset();
    d = $urandom_range(1, 20);
    run_noise(d);
    enter_settle_window(20);
    #2 nrst = 1'b0;
    #1;
    chk_out("areset_settle", 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);
    #3 nrst = 1'b1;
    edges = 0;
    hold = SETTLE + 10;
    for (int unsigned i = 0; i < hold; i++) begin
      gp_value = 32'd1;
      tick();
    end
    chk_out("after_areset", 1'b0, 1'b0, 1'b0, 31'd0, 32'(hold));

    // Asynchronous reset clears a finished result.
    write(TOHOST, 32'hB, 1'b1);
    tick();
    idle();
    chk_out("pre_areset_done", 1'b1, 1'b0, 1'b0, 31'd5, 32'(hold + 1));
    #2 nrst = 1'b0;
    #1;
    chk_out("areset_done", 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);
    #3 nrst = 1'b1;
    edges = 0;
    tick();
    tick();
    chk_out("post_areset_run", 1'b0, 1'b0, 1'b0, 31'd0, 32'd2);

`ifdef TEST_MONITOR_TIMEOUT_EN
    // Timeout at 100 cycles with no events.
    do_reset();
    for (int unsigned i = 0; i < 99; i++) begin
      tick();
    end
    chk_out("pre_timeout", 1'b0, 1'b0, 1'b0, 31'd0, 32'd99);
    tick();
    chk_out("timeout", 1'b1, 1'b0, 1'b1, 31'h7FFF_FFFF, 32'd100);
    write(TOHOST, 32'h1, 1'b1);
    tick();
    idle();
    chk_out("timeout_sticky", 1'b1, 1'b0, 1'b1, 31'h7FFF_FFFF, 32'd100);

    // Tohost on the last cycle wins over the timeout.
    do_reset();
    for (int unsigned i = 0; i < 99; i++) begin
      tick();
    end
    write(TOHOST, 32'h1, 1'b1);
    tick();
    idle();
    chk_out("timeout_prio", 1'b1, 1'b1, 1'b0, 31'd0, 32'd100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
